// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and load-stream format constants.
// Ports: none (package). Imported by the loader top and the word assembler.
// Stream: 2 length bytes MSB first, N words of 4 bytes MSB first, 1 XOR checksum byte.
package imem_loader_pkg;

   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_CHECK  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the loader's control, byte-stream and memory-write signals.
// Ports: start/in_valid/in_data driven by the host (master); in_ready, mem_we,
// mem_addr, mem_wdata, cpu_hold, done, err driven by the loader (slave).
interface imem_loader_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
   );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: shifts accepted bytes MSB first into a 32-bit word.
// Ports: clk, rst (async high), clr (session start), shift_en, byte_in ->
// word (registered), word_ready (combinational: the 4th byte is being taken now).
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_ready
);

   logic [1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word <= 32'd0;
         cnt  <= 2'd0;
      end else if (clr) begin
         word <= 32'd0;
         cnt  <= 2'd0;
      end else if (shift_en) begin
         word <= {word[23:0], byte_in};
         cnt  <= cnt + 2'd1;   // wraps to 0 after the last byte of a word
      end
   end

   assign word_ready = shift_en && (cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a length/words/checksum byte stream into instruction-memory writes.
// Ports: clk, rst (async high), bus (imem_loader_if.slave): start pulse, in_valid/
// in_data/in_ready byte handshake, mem_we/mem_addr/mem_wdata write port, cpu_hold/done/err.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int MEM_DEPTH = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus
);

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [16:0]       DEPTH17 = 17'(MEM_DEPTH);

   state_t            state, state_nxt;
   logic [15:0]       n;
   logic [15:0]       idx;
   logic [7:0]        acc;
   logic [ADDR_W-1:0] addr_q;
   logic              hold_q, done_q, err_q;
   logic              in_ready_c, mem_we_c;
   logic [31:0]       asm_word;
   logic              word_ready;

   wire        accept   = bus.in_valid && in_ready_c;
   wire        start_ok = bus.start && (state == S_IDLE || state == S_DONE);
   // Full length as it will be latched by the LEN_LO byte now on the bus.
   wire [15:0] len_full = {n[7:0], bus.in_data};
   wire        len_big  = {1'b0, len_full} > DEPTH17;

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clr        (start_ok),
      .shift_en   (accept && state == S_DATA),
      .byte_in    (bus.in_data),
      .word       (asm_word),
      .word_ready (word_ready)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start_ok) state_nxt = S_LEN_HI;
         S_LEN_HI:       if (accept) state_nxt = S_LEN_LO;
         S_LEN_LO: begin
            if (accept) begin
               if (len_full == 16'd0) state_nxt = S_CHECK;
               else if (len_big)      state_nxt = S_DONE;
               else                   state_nxt = S_DATA;
            end
         end
         S_DATA:         if (word_ready) state_nxt = S_WRITE;
         S_WRITE:        state_nxt = ((idx + 16'd1) == n) ? S_CHECK : S_DATA;
         S_CHECK:        if (accept) state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   // Output decode of the current state
   always_comb begin
      in_ready_c = 1'b0;
      mem_we_c   = 1'b0;
      case (state)
         S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: in_ready_c = 1'b1;
         S_WRITE:                             mem_we_c   = 1'b1;
         default: ;
      endcase
   end

   // Session datapath: length, word index, checksum, address and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n      <= 16'd0;
         idx    <= 16'd0;
         acc    <= 8'd0;
         addr_q <= BASE;
         hold_q <= 1'b1;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (start_ok) begin
         n      <= 16'd0;
         idx    <= 16'd0;
         acc    <= 8'd0;
         addr_q <= BASE;
         hold_q <= 1'b1;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            S_LEN_HI: if (accept) n <= len_full;
            S_LEN_LO: begin
               if (accept) begin
                  n <= len_full;
                  if (len_big) begin
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end
               end
            end
            S_DATA:  if (accept) acc <= acc ^ bus.in_data;
            S_WRITE: begin
               idx    <= idx + 16'd1;
               addr_q <= addr_q + 1'b1;   // tracks BASE_ADDR + idx, modulo 2^ADDR_W
            end
            S_CHECK: begin
               if (accept) begin
                  done_q <= 1'b1;
                  err_q  <= (bus.in_data != acc);
                  hold_q <= (bus.in_data != acc);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = asm_word;
   assign bus.cpu_hold  = hold_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives load streams into imem_loader and scores the writes and
// final status against a stream-level reference model; directed table plus random
// sessions, async reset mid-load and a start pulse during DATA.
module tb_imem_loader;

   localparam int ADDR_W    = 16;
   localparam int MEM_DEPTH = 256;
   localparam int BASE_ADDR = 0;
   localparam int BUDGET    = 8000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(
      .ADDR_W    (ADDR_W),
      .MEM_DEPTH (MEM_DEPTH),
      .BASE_ADDR (BASE_ADDR)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0]  stream[$];   // bytes still to be offered to the loader
   logic [47:0] wr_q[$];     // observed writes {addr, data}
   logic [47:0] exp_wr[$];   // model writes {addr, data}
   bit          exp_err;
   int          exp_cons;

   always @(negedge clk) begin
      if (!rst && bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: interprets the whole stream from the format rules.
   task automatic model();
      int nn;
      logic [7:0] x;
      logic [31:0] w;
      exp_wr.delete();
      nn = {stream[0], stream[1]};
      if (nn > MEM_DEPTH) begin
         exp_err  = 1'b1;
         exp_cons = 2;
      end else begin
         x = 8'h00;
         for (int i = 0; i < nn; i++) begin
            w = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            exp_wr.push_back({16'((BASE_ADDR + i) % 65536), w});
         end
         exp_err  = (stream[2+4*nn] != x);
         exp_cons = 3 + 4 * nn;
      end
   endtask

   task automatic build_stream(input int nn, input bit bad);
      logic [7:0] x;
      logic [7:0] b;
      logic [15:0] n16;
      n16 = 16'(nn);
      stream.delete();
      stream.push_back(n16[15:8]);
      stream.push_back(n16[7:0]);
      if (nn > MEM_DEPTH) begin
         stream.push_back(8'($urandom));
         stream.push_back(8'($urandom));
      end else begin
         x = 8'h00;
         for (int i = 0; i < 4 * nn; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            x = x ^ b;
         end
         stream.push_back(bad ? (x ^ 8'hA5) : x);
      end
   endtask

   task automatic run_stream(input int vprob, input int stop_w, input int glitch_at, output int left);
      int cycles;
      int consumed;
      bit glitched;
      cycles = 0;
      consumed = 0;
      glitched = 1'b0;
      wr_q.delete();
      @(negedge clk);
      bus.start = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      while (1) begin
         if (bus.done) break;
         if (stop_w > 0 && wr_q.size() >= stop_w) break;
         if (cycles >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done after %0d cycles", cycles);
            break;
         end
         if (!glitched && glitch_at == consumed) begin
            bus.start = 1'b1;
            bus.in_valid = 1'b0;
            glitched = 1'b1;
         end else begin
            bus.start = 1'b0;
            if (stream.size() > 0 && int'($urandom_range(99)) < vprob) begin
               bus.in_valid = 1'b1;
               bus.in_data  = stream[0];
               if (bus.in_ready) begin
                  void'(stream.pop_front());
                  consumed++;
               end
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         @(negedge clk);
         cycles++;
      end
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      left = stream.size();
   endtask

   task automatic check_session(input string nm, input bit e_err, input int e_nwr,
                                input int e_left, input int left);
      check({nm, " done"}, bus.done, 1);
      check({nm, " err"}, bus.err, e_err);
      check({nm, " cpu_hold"}, bus.cpu_hold, e_err);
      check({nm, " in_ready"}, bus.in_ready, 0);
      check({nm, " nwrites"}, wr_q.size(), e_nwr);
      for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
         check($sformatf("%s write%0d", nm, i), wr_q[i], exp_wr[i]);
      check({nm, " leftover"}, left, e_left);
   endtask

   typedef struct packed {
      logic [0:15][7:0] b;
      logic [7:0]       len;
      logic             e_err;
      logic [7:0]       e_nwr;
      logic [7:0]       e_left;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int left;
      int tot;
      int nn;
      bit bad;

      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;

      tbl[0] = '{b: {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                     8'hDE, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 len: 8'd11, e_err: 1'b0, e_nwr: 8'd2, e_left: 8'd0};
      tbl[1] = '{b: {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                     8'hDE, 8'hF0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 len: 8'd11, e_err: 1'b1, e_nwr: 8'd2, e_left: 8'd0};
      tbl[2] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 len: 8'd3, e_err: 1'b0, e_nwr: 8'd0, e_left: 8'd0};
      tbl[3] = '{b: {8'h01, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 len: 8'd5, e_err: 1'b1, e_nwr: 8'd0, e_left: 8'd3};
      tbl[4] = '{b: {8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 len: 8'd3, e_err: 1'b1, e_nwr: 8'd0, e_left: 8'd0};

      // Reset values while rst is held
      @(negedge clk);
      @(negedge clk);
      check("rst cpu_hold", bus.cpu_hold, 1);
      check("rst done", bus.done, 0);
      check("rst err", bus.err, 0);
      check("rst mem_we", bus.mem_we, 0);
      check("rst in_ready", bus.in_ready, 0);
      check("rst mem_addr", bus.mem_addr, BASE_ADDR);
      check("rst mem_wdata", bus.mem_wdata, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle in_ready", bus.in_ready, 0);

      // Directed table
      for (int t = 0; t < 5; t++) begin
         stream.delete();
         for (int k = 0; k < int'(tbl[t].len); k++) stream.push_back(tbl[t].b[k]);
         model();
         run_stream(100, 0, -1, left);
         check_session($sformatf("tbl%0d", t), tbl[t].e_err, int'(tbl[t].e_nwr),
                       int'(tbl[t].e_left), left);
      end

      // Start pulse during DATA must not disturb the word in progress
      stream.delete();
      stream.push_back(8'h00); stream.push_back(8'h01);
      stream.push_back(8'h12); stream.push_back(8'h34);
      stream.push_back(8'h56); stream.push_back(8'h78);
      stream.push_back(8'h08);
      model();
      run_stream(100, 0, 3, left);
      check_session("start_in_data", 1'b0, 1, 0, left);

      // Async reset between the 2nd and 3rd word of an N=4 load
      build_stream(4, 1'b0);
      model();
      run_stream(60, 2, -1, left);
      check("mid nwrites", wr_q.size(), 2);
      for (int i = 0; i < 2 && i < wr_q.size(); i++)
         check($sformatf("mid write%0d", i), wr_q[i], exp_wr[i]);
      #2 rst = 1'b1;
      #1;
      check("async in_ready", bus.in_ready, 0);
      check("async mem_we", bus.mem_we, 0);
      check("async cpu_hold", bus.cpu_hold, 1);
      check("async mem_addr", bus.mem_addr, BASE_ADDR);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data = 8'($urandom);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) @(negedge clk);
      bus.in_valid = 1'b0;
      check("post rst nwrites", wr_q.size(), 2);
      check("post rst in_ready", bus.in_ready, 0);
      build_stream(4, 1'b0);
      model();
      tot = stream.size();
      run_stream(100, 0, -1, left);
      check_session("reload", exp_err, exp_wr.size(), tot - exp_cons, left);

      // Boundary: N = MEM_DEPTH is accepted
      build_stream(MEM_DEPTH, 1'b0);
      model();
      tot = stream.size();
      run_stream(100, 0, -1, left);
      check_session("n_max", exp_err, exp_wr.size(), tot - exp_cons, left);

      // Random sessions with random valid gaps
      for (int r = 0; r < 12; r++) begin
         nn = int'($urandom_range(6));
         if (r == 3) nn = MEM_DEPTH + 5;
         bad = ($urandom_range(3) == 0);
         build_stream(nn, bad);
         model();
         tot = stream.size();
         run_stream(30 + int'($urandom_range(70)), 0, -1, left);
         check_session($sformatf("rnd%0d", r), exp_err, exp_wr.size(), tot - exp_cons, left);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 16, width of the instruction-memory word address.
REQ-002 Parameter MEM_DEPTH, default 256, number of 32-bit words in instruction memory.
REQ-003 Parameter BASE_ADDR, default 0, word address of the first loaded instruction.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that begins a load session.
REQ-007 in_valid  input  1  byte available on in_data.
REQ-008 in_data  input  8  load-stream byte.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 mem_we  output  1  instruction-memory write strobe.
REQ-011 mem_addr  output  ADDR_W  word address of the write.
REQ-012 mem_wdata  output  32  instruction word to write.
REQ-013 cpu_hold  output  1  holds the CPU in reset while high.
REQ-014 done  output  1  session finished (success or error).
REQ-015 err  output  1  session failed (length or checksum).

Function
REQ-016 A byte transfers only on a rising edge with in_valid=1 and in_ready=1.
REQ-017 Stream format: length N (16 bits, MSB first), then N words of 4 bytes each, MSB first, then one checksum byte.
REQ-018 The checksum SHALL equal the XOR of all 4N payload bytes; length bytes are excluded.
REQ-019 States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE.
REQ-020 IDLE: in_ready=0; on start, go to LEN_HI and clear done, err, word index and checksum accumulator.
REQ-021 LEN_HI / LEN_LO: in_ready=1; each accepted byte is latched into N; after LEN_LO, go to CHECK if N=0, go to DONE with err=1 if N>MEM_DEPTH, otherwise go to DATA.
REQ-022 DATA: in_ready=1; bytes shift into a 32-bit assembler; the 4th byte moves the state to WRITE.
REQ-023 WRITE: one cycle long, in_ready=0, mem_we=1, mem_addr=BASE_ADDR+index, mem_wdata=assembled word; then index increments and the state goes to CHECK if index+1=N, else to DATA.
REQ-024 mem_we SHALL be high only in WRITE, at exactly one cycle per word.
REQ-025 CHECK: in_ready=1; the accepted byte is compared with the accumulator; go to DONE with err=(mismatch).
REQ-026 DONE: in_ready=0, done=1; cpu_hold=0 if err=0, and stays 1 if err=1; start re-enters LEN_HI with cpu_hold=1, done=0, err=0.
REQ-027 start is ignored in every state except IDLE and DONE.
REQ-028 in_valid with in_ready=0 is not consumed; the byte SHALL be held by the sender.
REQ-029 mem_addr arithmetic is modulo 2^ADDR_W; index never exceeds N-1.
REQ-030 All outputs are registered except in_ready and mem_we, which decode the current state.

Reset
REQ-031 rst=1 SHALL force IDLE immediately, independent of clk.
REQ-032 Reset values: cpu_hold=1, done=0, err=0, mem_we=0, in_ready=0, mem_addr=BASE_ADDR, mem_wdata=0, index=0, N=0, accumulator=0.
REQ-033 Reset mid-session SHALL abandon the session with no further writes; words already written remain in memory.

Structure
REQ-034 Shared package holds the state encoding (3 bits) and the stream-format constants LEN_BYTES=2 and WORD_BYTES=4.
REQ-035 One sub-module, word_assembler, holds the 4-byte MSB-first shift register, byte counter and word_ready flag, and is cleared by rst or start.

Verification
REQ-036 Load N=2: bytes 00 02, 12 34 56 78, 9A BC DE F0, checksum 00 -> writes 0x12345678@0 and 0x9ABCDEF0@1, then done=1, err=0, cpu_hold=0.
REQ-037 Same stream with checksum 01 -> both writes occur, then done=1, err=1, cpu_hold=1.
REQ-038 N=0: bytes 00 00 00 -> no mem_we pulse, done=1, err=0.
REQ-039 N=MEM_DEPTH+1 -> no writes, done=1, err=1 immediately after LEN_LO; the remaining stream bytes see in_ready=0.
REQ-040 in_valid toggled randomly, and rst asserted between the 2nd and 3rd word of an N=4 load -> writes occur only while in_valid=1, rst takes effect asynchronously with no further writes, and a following start plus a clean stream loads correctly.
REQ-041 start pulsed during DATA -> ignored, with no change to index or the assembled word.
